icache_ser_arbiter: RTL and testbench
=====================================

Name: icache_ser_arbiter

Overview:
- Shares one serializer (SER) bus-request port between the even-bank and odd-bank instruction-cache miss engines.
- Each bank presents a miss request and destination. The arbiter picks one bank round-robin, drives the shared SER request/destination, and forwards grant and ack to the winning bank only.
- It then issues the release and enforces an ack timeout.
- Sits between the fetch-1 cache miss logic and the SER/bus interface.

Parameters:
- ACK_TIMEOUT, 64, max cycles in XFER waiting for SER ack before the abort/error path; legal range 2..255.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clk  in  1  single fetch clock
- reset  in  1  asynchronous active-low reset
- req_e  in  1  even bank miss request, level, held until ack_e or flush
- dest_e  in  4  even bank SER destination
- req_o  in  1  odd bank miss request
- dest_o  in  4  odd bank SER destination
- flush  in  1  resteer/invalidate; aborts any request not yet granted
- ser_grant  in  1  SER grant for the shared port
- ser_ack  in  1  SER transfer-complete ack
- ser_req  out  1  shared SER request
- ser_dest  out  4  shared SER destination
- ser_release  out  1  one-cycle release pulse
- grant_e  out  1  grant forwarded to even bank
- grant_o  out  1  grant forwarded to odd bank
- ack_e  out  1  ack forwarded to even bank, one-cycle pulse
- ack_o  out  1  ack forwarded to odd bank, one-cycle pulse
- owner  out  1  current owner: 0 = even, 1 = odd; valid when busy=1
- busy  out  1  arbiter not in IDLE
- timeout_err  out  1  sticky error; set on ack timeout, cleared only by reset

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; ser_dest=0; last_served=1, so even wins the first tie; counter=0.
- States: IDLE, REQ, XFER, REL. All outputs are registered.
- IDLE:
  - Any req_x asserted with flush=0 → REQ.
  - Owner chosen on the IDLE→REQ edge: if only one requester, that one; if both, the one not equal to last_served.
  - ser_dest latched from the owner's dest on the same edge.
  - ser_req=1 from the first REQ cycle (one cycle after request seen).
- REQ:
  - ser_req=1 held.
  - flush=1 → IDLE; ser_req drops next cycle; no release pulse; last_served unchanged.
  - ser_grant=1 (with flush=0) → XFER; grant_<owner>=1 from the next cycle, held through XFER; counter cleared.
  - flush and ser_grant in the same cycle: grant wins → XFER, because the bus is committed.
- XFER:
  - ser_req stays 1; counter increments each cycle.
  - flush is ignored.
  - ser_ack=1 → REL; ack_<owner> pulses 1 for exactly one cycle (the first REL cycle); grant_<owner> drops.
  - counter reaches ACK_TIMEOUT-1 with no ack → REL; timeout_err set; no ack pulse.
- REL:
  - ser_req=0; ser_release=1 for exactly one cycle.
  - last_served=owner.
  - Then → IDLE.
  - A pending request from either bank may win arbitration only from IDLE, so each transfer takes a minimum of 4 cycles: IDLE, REQ, XFER, REL.
- Requester dropping req_x while in REQ: no effect; the arbiter completes or flushes. Banks must not drop req except via flush.
- dest changes after latch are ignored until the next IDLE→REQ.
- grant_e and grant_o are never both 1; ack_e and ack_o are never both 1 (assertion required).
- ser_ack outside XFER is ignored; ser_grant outside REQ is ignored.
- Async reset mid-transfer returns to IDLE immediately and issues no release pulse. The SER side is reset by the same reset.

Test Plan:
- Single even miss: req_e=1, dest_e=4'h3; grant asserted in cycle 3, ack in cycle 6 → ser_req 1 from cycle 2, ser_dest=3, grant_e 1 in cycles 4–6, ack_e pulse at cycle 7, ser_release pulse at cycle 7, IDLE at cycle 8.
- Simultaneous req_e=req_o=1 after reset → even served first (owner=0); odd is then served next (owner=1), with no stall beyond the REL→IDLE cycle; third contention → even again.
- flush=1 while in REQ (before grant) → IDLE next cycle, ser_req=0, ser_release never pulses, last_served unchanged.
- flush and ser_grant in the same REQ cycle → XFER entered, grant forwarded, normal ack and release.
- No ack with ACK_TIMEOUT=8 → after 8 XFER cycles, REL, timeout_err=1 sticky, no ack_x pulse, ser_release pulse.
- reset driven low while in XFER → all outputs 0 asynchronously; after reset deasserts with req_o=1 → odd served normally.

Source files
------------

// File: rtl/icache_ser_arbiter.sv
// icache_ser_arbiter: round-robin share of one SER request port between even/odd icache miss engines
module icache_ser_arbiter #(
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_e,
  input  logic [3:0] dest_e,
  input  logic       req_o,
  input  logic [3:0] dest_o,
  input  logic       flush,
  input  logic       ser_grant,
  input  logic       ser_ack,
  output logic       ser_req,
  output logic [3:0] ser_dest,
  output logic       ser_release,
  output logic       grant_e,
  output logic       grant_o,
  output logic       ack_e,
  output logic       ack_o,
  output logic       owner,
  output logic       busy,
  output logic       timeout_err
);
  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;
  state_t     state_q, state_d;
  logic       owner_q, owner_d, last_q, last_d, win;
  logic [3:0] dest_q, dest_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       ser_req_q, ser_req_d, rel_q, rel_d, gnt_e_q, gnt_e_d, gnt_o_q, gnt_o_d;
  logic       ack_e_q, ack_e_d, ack_o_q, ack_o_d, busy_q, busy_d, err_q, err_d;
  logic       tmo;
  // with both banks requesting, the one not served last wins; reset leaves last=odd so even goes first
  assign win = (req_e && req_o) ? ~last_q : req_o;
  assign tmo = cnt_q == CNT_W'(ACK_TIMEOUT - 1);
  // next-state and registered-output computation; grant beats flush once the bus has committed
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    dest_d    = dest_q;
    cnt_d     = cnt_q;
    ser_req_d = ser_req_q;
    rel_d     = 1'b0;
    gnt_e_d   = gnt_e_q;
    gnt_o_d   = gnt_o_q;
    ack_e_d   = 1'b0;
    ack_o_d   = 1'b0;
    busy_d    = busy_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (!flush && (req_e || req_o)) begin
        state_d   = REQ;
        owner_d   = win;
        dest_d    = win ? dest_o : dest_e;
        ser_req_d = 1'b1;
        busy_d    = 1'b1;
      end
      REQ: if (ser_grant) begin
        state_d = XFER;
        gnt_e_d = ~owner_q;
        gnt_o_d = owner_q;
        cnt_d   = '0;
      end else if (flush) begin
        state_d   = IDLE;
        ser_req_d = 1'b0;
        busy_d    = 1'b0;
      end
      XFER: if (ser_ack || tmo) begin
        state_d   = REL;
        ser_req_d = 1'b0;
        rel_d     = 1'b1;
        gnt_e_d   = 1'b0;
        gnt_o_d   = 1'b0;
        ack_e_d   = ser_ack && !owner_q;
        ack_o_d   = ser_ack && owner_q;
        err_d     = err_q || !ser_ack;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        last_d  = owner_q;
      end
    endcase
  end
  // state and output registers; async reset drops everything with no release pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      dest_q    <= '0;
      cnt_q     <= '0;
      ser_req_q <= 1'b0;
      rel_q     <= 1'b0;
      gnt_e_q   <= 1'b0;
      gnt_o_q   <= 1'b0;
      ack_e_q   <= 1'b0;
      ack_o_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      dest_q    <= dest_d;
      cnt_q     <= cnt_d;
      ser_req_q <= ser_req_d;
      rel_q     <= rel_d;
      gnt_e_q   <= gnt_e_d;
      gnt_o_q   <= gnt_o_d;
      ack_e_q   <= ack_e_d;
      ack_o_q   <= ack_o_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end
  assign ser_req     = ser_req_q;
  assign ser_dest    = dest_q;
  assign ser_release = rel_q;
  assign grant_e     = gnt_e_q;
  assign grant_o     = gnt_o_q;
  assign ack_e       = ack_e_q;
  assign ack_o       = ack_o_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;
  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset) !(grant_e && grant_o));
  a_ack_onehot: assert property (@(posedge clk) disable iff (!reset) !(ack_e && ack_o));
endmodule

// File: tb/tb_icache_ser_arbiter.sv
// tb_icache_ser_arbiter: directed scenario checks for the icache SER arbiter
module tb_icache_ser_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_e = 1'b0, req_o = 1'b0, flush = 1'b0, ser_grant = 1'b0, ser_ack = 1'b0;
  logic [3:0] dest_e = 4'h0, dest_o = 4'h0;
  logic       ser_req, ser_release, grant_e, grant_o, ack_e, ack_o, owner, busy, timeout_err;
  logic [3:0] ser_dest;
  logic [8:0] obs;
  int tests = 0;
  int fails = 0;
  icache_ser_arbiter #(.ACK_TIMEOUT(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_e(req_e), .dest_e(dest_e), .req_o(req_o), .dest_o(dest_o),
    .flush(flush), .ser_grant(ser_grant), .ser_ack(ser_ack), .ser_req(ser_req), .ser_dest(ser_dest),
    .ser_release(ser_release), .grant_e(grant_e), .grant_o(grant_o), .ack_e(ack_e), .ack_o(ack_o),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  // {ser_req, ser_release, grant_e, grant_o, ack_e, ack_o, owner, busy, timeout_err}
  assign obs = {ser_req, ser_release, grant_e, grant_o, ack_e, ack_o, owner, busy, timeout_err};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    {req_e, req_o, flush, ser_grant, ser_ack} = '0;
    #2;
    reset = 1'b1;
    tick();
  endtask
  task automatic test_reset();
    #2;
    tests++; if (obs !== 9'b0 || ser_dest !== 4'h0) begin fails++; $display("FAIL reset obs=%b dest=%h exp=%b/%h", obs, ser_dest, 9'b0, 4'h0); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    tests++; if (obs !== 9'b0) begin fails++; $display("FAIL reset_idle obs=%b exp=%b", obs, 9'b0); end
  endtask
  task automatic test_single_even();
    req_e = 1'b1; dest_e = 4'h3;
    tick();
    tests++; if (obs !== 9'b100000010 || ser_dest !== 4'h3) begin fails++; $display("FAIL even_req obs=%b dest=%h exp=%b/%h", obs, ser_dest, 9'b100000010, 4'h3); end
    tick();
    tests++; if (obs !== 9'b100000010) begin fails++; $display("FAIL even_req_hold obs=%b exp=%b", obs, 9'b100000010); end
    ser_grant = 1'b1;
    tick();
    ser_grant = 1'b0; dest_e = 4'h5;
    tests++; if (obs !== 9'b101000010 || ser_dest !== 4'h3) begin fails++; $display("FAIL even_xfer obs=%b dest=%h exp=%b/%h", obs, ser_dest, 9'b101000010, 4'h3); end
    tick();
    tick();
    tests++; if (obs !== 9'b101000010 || ser_dest !== 4'h3) begin fails++; $display("FAIL even_xfer_hold obs=%b dest=%h exp=%b/%h", obs, ser_dest, 9'b101000010, 4'h3); end
    ser_ack = 1'b1;
    tick();
    ser_ack = 1'b0; req_e = 1'b0;
    tests++; if (obs !== 9'b010010010) begin fails++; $display("FAIL even_rel obs=%b exp=%b", obs, 9'b010010010); end
    tick();
    tests++; if (obs !== 9'b000000000) begin fails++; $display("FAIL even_idle obs=%b exp=%b", obs, 9'b0); end
  endtask
  task automatic test_round_robin();
    do_reset();
    req_e = 1'b1; req_o = 1'b1; dest_e = 4'h1; dest_o = 4'h2;
    tick();
    tests++; if (obs !== 9'b100000010 || ser_dest !== 4'h1) begin fails++; $display("FAIL rr1_req obs=%b dest=%h exp=%b/%h", obs, ser_dest, 9'b100000010, 4'h1); end
    ser_grant = 1'b1;
    tick();
    ser_grant = 1'b0; ser_ack = 1'b1;
    tick();
    ser_ack = 1'b0; req_e = 1'b0;
    tests++; if (obs !== 9'b010010010) begin fails++; $display("FAIL rr1_rel obs=%b exp=%b", obs, 9'b010010010); end
    tick();
    tick();
    tests++; if (obs !== 9'b100000110 || ser_dest !== 4'h2) begin fails++; $display("FAIL rr2_req obs=%b dest=%h exp=%b/%h", obs, ser_dest, 9'b100000110, 4'h2); end
    ser_grant = 1'b1;
    tick();
    ser_grant = 1'b0;
    tests++; if (obs !== 9'b100100110) begin fails++; $display("FAIL rr2_xfer obs=%b exp=%b", obs, 9'b100100110); end
    ser_ack = 1'b1;
    tick();
    ser_ack = 1'b0; req_e = 1'b1;
    tests++; if (obs !== 9'b010001110) begin fails++; $display("FAIL rr2_rel obs=%b exp=%b", obs, 9'b010001110); end
    tick();
    tick();
    tests++; if (obs !== 9'b100000010 || ser_dest !== 4'h1) begin fails++; $display("FAIL rr3_req obs=%b dest=%h exp=%b/%h", obs, ser_dest, 9'b100000010, 4'h1); end
    ser_grant = 1'b1;
    tick();
    ser_grant = 1'b0; ser_ack = 1'b1;
    tick();
    ser_ack = 1'b0; req_e = 1'b0; req_o = 1'b0;
    tick();
  endtask
  task automatic test_flush();
    req_e = 1'b1; req_o = 1'b1;
    tick();
    tests++; if (obs !== 9'b100000110) begin fails++; $display("FAIL flush_req obs=%b exp=%b", obs, 9'b100000110); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests++; if (obs !== 9'b000000100) begin fails++; $display("FAIL flush_idle obs=%b exp=%b", obs, 9'b000000100); end
    tick();
    tests++; if (obs !== 9'b100000110) begin fails++; $display("FAIL flush_rearb obs=%b exp=%b", obs, 9'b100000110); end
  endtask
  task automatic test_flush_grant();
    flush = 1'b1; ser_grant = 1'b1;
    tick();
    flush = 1'b0; ser_grant = 1'b0;
    tests++; if (obs !== 9'b100100110) begin fails++; $display("FAIL fg_xfer obs=%b exp=%b", obs, 9'b100100110); end
    ser_ack = 1'b1;
    tick();
    ser_ack = 1'b0; req_e = 1'b0; req_o = 1'b0;
    tests++; if (obs !== 9'b010001110) begin fails++; $display("FAIL fg_rel obs=%b exp=%b", obs, 9'b010001110); end
    tick();
    tests++; if (obs !== 9'b000000100) begin fails++; $display("FAIL fg_idle obs=%b exp=%b", obs, 9'b000000100); end
  endtask
  task automatic test_timeout();
    req_o = 1'b1;
    tick();
    ser_grant = 1'b1;
    tick();
    ser_grant = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      tests++; if (obs !== 9'b100100110) begin fails++; $display("FAIL tmo_xfer%0d obs=%b exp=%b", i, obs, 9'b100100110); end
    end
    tick();
    req_o = 1'b0;
    tests++; if (obs !== 9'b010000111) begin fails++; $display("FAIL tmo_rel obs=%b exp=%b", obs, 9'b010000111); end
    tick();
    tick();
    tests++; if (obs !== 9'b000000101) begin fails++; $display("FAIL tmo_sticky obs=%b exp=%b", obs, 9'b000000101); end
  endtask
  task automatic test_async_reset();
    req_e = 1'b1; dest_e = 4'h7;
    tick();
    ser_grant = 1'b1;
    tick();
    ser_grant = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    tests++; if (obs !== 9'b0 || ser_dest !== 4'h0) begin fails++; $display("FAIL async_rst obs=%b dest=%h exp=%b/%h", obs, ser_dest, 9'b0, 4'h0); end
    req_e = 1'b0; req_o = 1'b1; dest_o = 4'h9;
    @(negedge clk);
    reset = 1'b1;
    tick();
    tests++; if (obs !== 9'b100000110 || ser_dest !== 4'h9) begin fails++; $display("FAIL post_rst_req obs=%b dest=%h exp=%b/%h", obs, ser_dest, 9'b100000110, 4'h9); end
    ser_grant = 1'b1;
    tick();
    ser_grant = 1'b0; ser_ack = 1'b1;
    tick();
    ser_ack = 1'b0; req_o = 1'b0;
    tests++; if (obs !== 9'b010001110) begin fails++; $display("FAIL post_rst_rel obs=%b exp=%b", obs, 9'b010001110); end
  endtask
  initial begin
    test_reset();
    test_single_even();
    test_round_robin();
    test_flush();
    test_flush_grant();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
